// File: rtl/led_pkg.sv
// Shared mode encodings for the LED pattern generator.
package led_pkg;

  localparam logic [1:0] MODE_ROL    = 2'd0;
  localparam logic [1:0] MODE_ROR    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

endpackage

// File: rtl/tick_divider.sv
// Programmable tick divider: one-cycle tick every div+1 enabled clocks.
module tick_divider #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;
  logic                 at_limit;

  // >= rather than == so lowering div below the current count ends the period at once
  assign at_limit = (count >= div);
  assign tick     = enable && !clear && at_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (at_limit) begin
        count <= '0;
      end else begin
        count <= count + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate, bounce or blink a WIDTH-bit pattern on each divider tick.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int                   WIDTH        = 8,
  parameter logic [WIDTH-1:0]     INIT_PATTERN = WIDTH'(2'b11),
  parameter int                   DIV_WIDTH    = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_pattern,
  output logic [WIDTH-1:0]     leds,
  output logic                 step,
  output logic                 dir
);

  logic             tick;
  logic [WIDTH-1:0] next_leds;
  logic             next_dir;

  tick_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (load),
    .div    (div),
    .tick   (tick)
  );

  always_comb begin
    next_leds = leds;
    next_dir  = dir;
    case (mode)
      MODE_ROL: next_leds = {leds[WIDTH-2:0], leds[WIDTH-1]};
      MODE_ROR: next_leds = {leds[0], leds[WIDTH-1:1]};
      MODE_BOUNCE: begin
        // Both ends lit leaves nowhere to move: hold value and direction
        if (!(leds[WIDTH-1] && leds[0])) begin
          if (!dir) begin
            if (leds[WIDTH-1]) begin
              next_dir  = 1'b1;
              next_leds = leds >> 1;
            end else begin
              next_leds = leds << 1;
            end
          end else begin
            if (leds[0]) begin
              next_dir  = 1'b0;
              next_leds = leds << 1;
            end else begin
              next_leds = leds >> 1;
            end
          end
        end
      end
      default: next_leds = ~leds;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds <= INIT_PATTERN;
      dir  <= 1'b0;
      step <= 1'b0;
    end else if (load) begin
      leds <= load_pattern;
      dir  <= 1'b0;
      step <= 1'b0;
    end else if (tick) begin
      leds <= next_leds;
      dir  <= next_dir;
      step <= 1'b1;
    end else begin
      step <= 1'b0;
    end
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern generator: a WIDTH-bit pattern register that advances once per programmable tick.
- Four modes: rotate left, rotate right, bounce (ping-pong) and blink (invert).
- Runtime pattern load, enable/pause, and a step strobe for status logic.
- Sits beside the UART mux as the board activity/status LED driver.
- Replaces fixed-width, fixed-rate LED shifters.

Parameters:
WIDTH, 8, number of LEDs / pattern bits (>= 2)
INIT_PATTERN, 'b11 (zero-extended to WIDTH), pattern value after reset
DIV_WIDTH, 24, width of tick divider counter and div port

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = divider runs and pattern advances; 0 = freeze counter and pattern
mode  input  2  0 ROL, 1 ROR, 2 BOUNCE, 3 BLINK; sampled on each tick
div  input  DIV_WIDTH  tick period minus one, in clk cycles
load  input  1  single-cycle pattern load request
load_pattern  input  WIDTH  value written on load
leds  output  WIDTH  current pattern
step  output  1  one-cycle pulse: leds changed due to a tick this cycle
dir  output  1  bounce direction: 0 = left (toward MSB), 1 = right

Behaviour:
Clock and reset
- One clock domain (clk).
- reset is asynchronous, active-high. It immediately forces: leds=INIT_PATTERN, step=0, dir=0, divider count=0.
- Release of reset is synchronised by the surrounding design; the block assumes a clean deassertion.

Divider
- Count increments each clk edge while enable=1.
- When count >= div: tick=1 internally and count <= 0. The >= comparison covers div being lowered below the current count.
- Resulting period is div+1 cycles; div=0 gives a tick every cycle.
- enable=0: count holds, no tick, leds hold, step=0.

Pattern update on tick (clock edge with tick=1 and load=0)
- ROL: leds <= {leds[WIDTH-2:0], leds[WIDTH-1]}.
- ROR: leds <= {leds[0], leds[WIDTH-1:1]}.
- BOUNCE: zero-fill shifts, no wrap.
  - dir=0 and leds[WIDTH-1]=0: shift left.
  - dir=0 and leds[WIDTH-1]=1: dir <= 1, shift right.
  - dir=1 and leds[0]=0: shift right.
  - dir=1 and leds[0]=1: dir <= 0, shift left.
  - MSB and LSB both set (e.g. all ones): leds and dir hold.
  - leds all zero: leds hold.
- BLINK: leds <= ~leds.
- dir changes only in BOUNCE. It is retained across mode changes.

Step strobe
- step is registered: high for exactly the one cycle in which the newly updated leds value is visible.
- step is asserted even when BOUNCE holds the value.

Load
- load=1 has priority over tick in the same cycle. At that edge: leds <= load_pattern, dir <= 0, count <= 0, step <= 0.
- Load works with enable=0.

Other boundary rules
- A mode change takes effect at the next tick. No glitch, no reset of the divider.
- Reset asserted mid-period aborts immediately. The first tick after release occurs div+1 enabled cycles later.

Decomposition:
- Shared package led_pkg: localparams MODE_ROL=2'd0, MODE_ROR=2'd1, MODE_BOUNCE=2'd2, MODE_BLINK=2'd3.
- Sub-module tick_divider (parameter DIV_WIDTH; ports clk, reset, enable, clear, div, tick) implements the divider. clear is driven by load.
- The pattern/direction register and next-state logic stay in led_pattern_gen.

Test Plan:
All scenarios use WIDTH=4, INIT_PATTERN=4'b0011.
1. Reset release, mode=ROL, div=2, enable=1 -> leds 0011, 0110, 1100, 1001, 0011, updating every 3 cycles; step=1 on each update cycle only.
2. mode=BOUNCE, div=0 from 0011 -> one step per cycle: 0110, 1100 (dir=0); then 0110 (dir=1), 0011; then 0110 (dir=0).
3. mode=BLINK, div=1 -> 0011, 1100, 0011 every 2 cycles. Drop enable for 5 cycles -> leds/step frozen; resume -> next tick 2 enabled cycles later.
4. load=1 with load_pattern=1000 on the same cycle as a tick, mode=ROR -> leds=1000, step=0, dir=0. Next update 0100 after div+1 cycles. All-ones load in BOUNCE -> leds stays 1111, step still pulses.
5. Assert reset asynchronously mid-period (no clk edge) -> leds=0011, step=0, dir=0 immediately. Lower div from 10 to 2 while count=7 -> tick on next edge, then 3-cycle period.
